// File: rtl/aoi22_skid_stage_pkg.sv
// Shared types and defaults for the AOI22 skid stage: state encoding and default widths.
// Latency: n/a; backpressure: n/a.
package aoi22_skid_stage_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

    // 2'b11 is deliberately absent; the stage steers it back to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    function automatic logic state_accepts(input state_t st);
        return (st != ST_FULL);
    endfunction

endpackage

// File: rtl/aoi22_vec.sv
// Bitwise AOI22 evaluator: zn = ~((a1 & a2) | (b1 & b2)).
// Latency: 0 cycles (combinational); backpressure: none.
module aoi22_vec
    import aoi22_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    output logic [WIDTH-1:0] zn
);

    assign zn = ~((a1 & a2) | (b1 & b2));

endmodule

// File: rtl/aoi22_skid_stage.sv
// Registered AOI22 stage with a 2-entry skid buffer and a saturating output-transfer counter.
// Latency: 1 cycle when empty; backpressure: in_ready is registered, drops only when both entries are held.
module aoi22_skid_stage
    import aoi22_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_zn,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] m_nxt;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_nxt;
    logic             in_rdy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] res_dat;
    logic             out_vld;
    logic             in_xfer;
    logic             out_xfer;

    aoi22_vec #(
        .WIDTH(WIDTH)
    ) u_vec (
        .a1(a1),
        .a2(a2),
        .b1(b1),
        .b2(b2),
        .zn(res_dat)
    );

    assign out_vld  = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign in_xfer  = in_valid && in_rdy_q;
    assign out_xfer = out_vld && out_ready;

    always_comb begin
        state_nxt = state_q;
        m_nxt     = m_q;
        s_nxt     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    m_nxt     = res_dat;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    m_nxt = res_dat;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end else if (in_xfer) begin
                    s_nxt     = res_dat;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_xfer) begin
                    m_nxt     = s_q;
                    state_nxt = ST_ONE;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    // in_ready is derived from the next state so it never sees out_ready combinationally.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_EMPTY;
            m_q      <= '0;
            s_q      <= '0;
            in_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            m_q      <= m_nxt;
            s_q      <= s_nxt;
            in_rdy_q <= state_accepts(state_nxt);
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            cnt_q <= '0;
        end else if (out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld;
    assign out_zn    = m_q;
    assign xfer_cnt  = cnt_q;

endmodule
